// File: rtl/lane_shift_pkg.sv
// rtl/lane_shift_pkg.sv - shared parameters and types for the sequential lane right-shifter
package lane_shift_pkg;

    localparam int LANE_W       = 12;
    localparam int NUM_LANES    = 8;
    localparam int DATA_W       = LANE_W * NUM_LANES;
    localparam int SHIFT_W      = 3;
    localparam int MAX_OK_SHIFT = 5;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/lane_shr_step.sv
// rtl/lane_shr_step.sv - one-lane right shift, fill lane enters at the top
module lane_shr_step
    import lane_shift_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  lane_t             fill_i,
    output logic [DATA_W-1:0] data_o
);

    assign data_o = {fill_i, data_i[DATA_W-1:LANE_W]};

endmodule

// File: rtl/lane_shift_right_seq.sv
// rtl/lane_shift_right_seq.sv - handshaked right shift by whole lanes, one lane per cycle
module lane_shift_right_seq
    import lane_shift_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in,
    input  logic [SHIFT_W-1:0] shift,
    input  lane_t              fill,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out,
    output logic               out_ok
);

    state_e             state_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  data_d;
    logic [SHIFT_W-1:0] cnt_q;
    lane_t              fill_q;
    logic               ok_q;
    logic               in_ready_q;
    logic               out_valid_q;

    lane_shr_step u_step (
        .data_i (data_q),
        .fill_i (fill_q),
        .data_o (data_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            fill_q      <= '0;
            ok_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= in;
                        cnt_q      <= shift;
                        fill_q     <= fill;
                        ok_q       <= (shift <= SHIFT_W'(MAX_OK_SHIFT));
                        in_ready_q <= 1'b0;
                        if (shift == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - SHIFT_W'(1);
                    if (cnt_q == SHIFT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // out_valid and in_ready swap on the same edge so they never overlap
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = data_q;
    assign out_ok    = ok_q;

endmodule

// File: tb/tb_lane_shift_right_seq.sv
// tb/tb_lane_shift_right_seq.sv - vector table and scoreboard bench for lane_shift_right_seq
module tb_lane_shift_right_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] din;
    logic [2:0]  sh;
    logic [11:0] fl;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] dout;
    logic        out_ok;

    lane_shift_right_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .shift     (sh),
        .fill      (fl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .out_ok    (out_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] din;
        logic [2:0]  sh;
        logic [11:0] fl;
        logic [95:0] exp_out;
        logic        exp_ok;
    } vec_t;

    typedef struct {
        logic [95:0] o;
        logic        ok;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[8];
    int   n_total = 0;
    int   n_pass  = 0;

    localparam logic [95:0] PLAN_IN = 96'h000_111_222_333_444_555_666_777;

    function automatic logic [95:0] model(input logic [95:0] d, input logic [2:0] s,
                                          input logic [11:0] f);
        logic [95:0] r;
        for (int i = 0; i < 8; i++)
            r[i*12 +: 12] = (i + int'(s) < 8) ? d[(i + int'(s))*12 +: 12] : f;
        return r;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_exp(input logic [95:0] o, input logic ok, input logic [2:0] s);
        exp_t e;
        e.o   = o;
        e.ok  = ok;
        e.lat = int'(s) + 1;
        sbq.push_back(e);
    endtask

    // Called on the first negedge after the accept edge; lat counts edges from the accept edge.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string nm, input int lat);
        exp_t e;
        if (sbq.size() == 0) begin
            check({nm, "_sb_empty"}, 96'd1, 96'd0);
            return;
        end
        e = sbq.pop_front();
        check({nm, "_valid"}, 96'(out_valid), 96'd1);
        check({nm, "_out"}, dout, e.o);
        check({nm, "_ok"}, 96'(out_ok), 96'(e.ok));
        check({nm, "_lat"}, 96'(lat), 96'(e.lat));
        check({nm, "_rdy_lo"}, 96'(in_ready), 96'd0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        in_valid = 1'b1;
        din = v.din;
        sh  = v.sh;
        fl  = v.fl;
        push_exp(v.exp_out, v.exp_ok, v.sh);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        din = {3{32'hDEADBEEF}};
        sh  = ~v.sh;
        fl  = 12'h5A5;
        wait_valid(lat);
        check_result(nm, lat);
        @(negedge clk);
        check({nm, "_idle_valid"}, 96'(out_valid), 96'd0);
        check({nm, "_idle_ready"}, 96'(in_ready), 96'd1);
    endtask

    initial begin
        logic [95:0] d;
        logic [95:0] held_out;
        logic        held_ok;
        int          lat;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        din = '0;
        sh = '0;
        fl = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 96'(in_ready), 96'd1);
        check("rst_valid", 96'(out_valid), 96'd0);
        check("rst_out", dout, 96'd0);
        check("rst_ok", 96'(out_ok), 96'd0);
        rst_n = 1'b1;

        // Asynchronous reset two cycles into a shift-5 request
        @(negedge clk);
        in_valid = 1'b1;
        din = PLAN_IN;
        sh = 3'd5;
        fl = 12'h321;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 96'(in_ready), 96'd1);
        check("midrst_valid", 96'(out_valid), 96'd0);
        check("midrst_out", dout, 96'd0);
        check("midrst_ok", 96'(out_ok), 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{PLAN_IN, 3'd0, 12'hABC, PLAN_IN, 1'b1};
        vecs[1] = '{PLAN_IN, 3'd3, 12'hABC, 96'hABC_ABC_ABC_000_111_222_333_444, 1'b1};
        vecs[2] = '{PLAN_IN, 3'd7, 12'hFFF, 96'hFFF_FFF_FFF_FFF_FFF_FFF_FFF_000, 1'b0};
        vecs[3] = '{PLAN_IN, 3'd5, 12'h0F0, 96'h0F0_0F0_0F0_0F0_0F0_000_111_222, 1'b1};
        vecs[4] = '{PLAN_IN, 3'd6, 12'h123, 96'h123_123_123_123_123_123_000_111, 1'b0};
        for (int k = 5; k < 8; k++) begin
            vecs[k].din = {$urandom, $urandom, $urandom};
            vecs[k].sh  = 3'(k - 4);
            vecs[k].fl  = 12'($urandom);
            vecs[k].exp_out = model(vecs[k].din, vecs[k].sh, vecs[k].fl);
            vecs[k].exp_ok  = 1'b1;
        end
        for (int k = 0; k < 8; k++)
            run_vec(vecs[k], $sformatf("vec%0d", k));

        // Backpressure: shift-1 result held with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1;
        din = PLAN_IN;
        sh = 3'd1;
        fl = 12'h9C9;
        push_exp(model(PLAN_IN, 3'd1, 12'h9C9), 1'b1, 3'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check_result("bp", lat);
        held_out = dout;
        held_ok = out_ok;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_out", c), dout, held_out);
            check($sformatf("bp_hold%0d_ok", c), 96'(out_ok), 96'(held_ok));
            check($sformatf("bp_hold%0d_valid", c), 96'(out_valid), 96'd1);
            check($sformatf("bp_hold%0d_rdy", c), 96'(in_ready), 96'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_valid", 96'(out_valid), 96'd0);
        check("bp_rel_ready", 96'(in_ready), 96'd1);

        // Back-to-back with inputs changed right after the first accept
        in_valid = 1'b1;
        din = PLAN_IN;
        sh = 3'd2;
        fl = 12'h0F0;
        push_exp(96'h0F0_0F0_000_111_222_333_444_555, 1'b1, 3'd2);
        @(posedge clk);
        @(negedge clk);
        d = {$urandom, $urandom, $urandom};
        din = d;
        sh = 3'd1;
        fl = 12'hEEE;
        push_exp(model(d, 3'd1, 12'hEEE), 1'b1, 3'd1);
        wait_valid(lat);
        check_result("b2b_a", lat);
        @(negedge clk);
        check("b2b_gap_ready", 96'(in_ready), 96'd1);
        check("b2b_gap_valid", 96'(out_valid), 96'd0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check_result("b2b_b", lat);
        @(negedge clk);
        check("sb_drained", 96'(sbq.size()), 96'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
